// File: rtl/ascii_7seg_scan.sv
// Time-multiplexed ASCII driver for an N-digit common-anode 7-segment display.
// Holds a writable character buffer and supports static display or right-to-left marquee.
module ascii_7seg_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned BUF_DEPTH   = 16,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned SCROLL_DIV  = 12500000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic                         scroll_en,
    input  logic [$clog2(BUF_DEPTH):0]   msg_len,
    output logic [7:0]                   seg,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         scroll_wrap
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned SW = $clog2(SCROLL_DIV);

    localparam logic [RW-1:0] RefreshLast = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] ScrollLast  = SW'(SCROLL_DIV - 1);
    localparam logic [KW-1:0] DigitLast   = KW'(NUM_DIGITS - 1);
    localparam logic [AW:0]   DepthLen    = (AW + 1)'(BUF_DEPTH);
    localparam logic [AW:0]   DigitsLen   = (AW + 1)'(NUM_DIGITS);
    localparam logic [7:0]    Space       = 8'h20;

    logic [7:0]            bufQ [BUF_DEPTH];
    logic [RW-1:0]         refreshCntQ, refreshCntD;
    logic [KW-1:0]         digitQ, digitD;
    logic [SW-1:0]         scrollCntQ, scrollCntD;
    logic [AW-1:0]         offsetQ, offsetD;
    logic                  wrapQ, wrapD;
    logic [7:0]            segD;
    logic [NUM_DIGITS-1:0] anD;

    logic [AW:0]   effLen;
    logic          scrollActive;
    logic          refreshTick;
    logic          scrollTick;
    logic [AW:0]   nextOffset;
    logic [AW:0]   sumIdx;
    logic [AW:0]   wrapIdx;
    logic [AW-1:0] charIdx;
    logic [7:0]    charSel;

    // Returns seg[6:0] (active low) for the upper-cased code; unknown codes are blank.
    function automatic logic [6:0] decodeAscii(input logic [6:0] code);
        logic [6:0] up;
        logic [6:0] glyph;
        up = code;
        if (code >= 7'h61 && code <= 7'h7A) begin
            up = code - 7'h20;
        end
        case (up)
            7'h30:   glyph = 7'h40;
            7'h31:   glyph = 7'h79;
            7'h32:   glyph = 7'h24;
            7'h33:   glyph = 7'h30;
            7'h34:   glyph = 7'h19;
            7'h35:   glyph = 7'h12;
            7'h36:   glyph = 7'h02;
            7'h37:   glyph = 7'h78;
            7'h38:   glyph = 7'h00;
            7'h39:   glyph = 7'h10;
            7'h41:   glyph = 7'h08;
            7'h42:   glyph = 7'h03;
            7'h43:   glyph = 7'h46;
            7'h44:   glyph = 7'h21;
            7'h45:   glyph = 7'h06;
            7'h46:   glyph = 7'h0E;
            7'h48:   glyph = 7'h09;
            7'h4C:   glyph = 7'h47;
            7'h50:   glyph = 7'h0C;
            7'h55:   glyph = 7'h41;
            7'h2D:   glyph = 7'h3F;
            7'h5F:   glyph = 7'h77;
            default: glyph = 7'h7F;
        endcase
        return glyph;
    endfunction

    assign effLen       = (msg_len > DepthLen) ? DepthLen : msg_len;
    assign scrollActive = scroll_en && (effLen >= DigitsLen);
    assign refreshTick  = (refreshCntQ == RefreshLast);
    assign scrollTick   = (scrollCntQ == ScrollLast);

    always_comb begin
        refreshCntD = refreshTick ? '0 : refreshCntQ + 1'b1;
        digitD      = digitQ;
        if (refreshTick) begin
            digitD = (digitQ == DigitLast) ? '0 : digitQ + 1'b1;
        end
    end

    always_comb begin
        scrollCntD = scrollCntQ;
        offsetD    = offsetQ;
        wrapD      = 1'b0;
        nextOffset = {1'b0, offsetQ} + 1'b1;
        if (!scrollActive) begin
            scrollCntD = '0;
            offsetD    = '0;
        end else begin
            scrollCntD = scrollTick ? '0 : scrollCntQ + 1'b1;
            // A shrunken message can leave the offset out of range; recover silently.
            if ({1'b0, offsetQ} >= effLen) begin
                offsetD = '0;
            end else if (scrollTick) begin
                if (nextOffset >= effLen) begin
                    offsetD = '0;
                    wrapD   = 1'b1;
                end else begin
                    offsetD = nextOffset[AW-1:0];
                end
            end
        end
    end

    // offset < effLen, so one conditional subtraction keeps the index in range.
    always_comb begin
        sumIdx  = {1'b0, offsetQ} + (AW + 1)'(digitQ);
        wrapIdx = (sumIdx >= effLen) ? sumIdx - effLen : sumIdx;
        charIdx = scrollActive ? wrapIdx[AW-1:0] : AW'(digitQ);
        charSel = bufQ[charIdx];
        segD    = {~charSel[7], decodeAscii(charSel[6:0])};
        anD     = ~(NUM_DIGITS'(1) << (DigitLast - digitQ));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refreshCntQ <= '0;
            digitQ      <= '0;
            scrollCntQ  <= '0;
            offsetQ     <= '0;
            wrapQ       <= 1'b0;
            seg         <= 8'hFF;
            an          <= '1;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                bufQ[AW'(i)] <= Space;
            end
        end else begin
            refreshCntQ <= refreshCntD;
            digitQ      <= digitD;
            scrollCntQ  <= scrollCntD;
            offsetQ     <= offsetD;
            wrapQ       <= wrapD;
            seg         <= segD;
            an          <= anD;
            if (wr_en) begin
                bufQ[wr_addr] <= wr_data;
            end
        end
    end

    assign scroll_wrap = wrapQ;

endmodule

// File: tb/tb_ascii_7seg_scan.sv
// Scoreboard bench for ascii_7seg_scan: expected {an, seg, scroll_wrap} per cycle are
// queued from the bench's own timing model and popped as the DUT produces each output.
module tb_ascii_7seg_scan;

    localparam int ND = 4;
    localparam int BD = 8;
    localparam int RD = 4;
    localparam int SD = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       scroll_en = 1'b0;
    logic [3:0] msg_len = '0;
    logic [7:0] seg;
    logic [3:0] an;
    logic       scroll_wrap;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       wrap;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [7:0] numSeg  [0:5] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    logic [7:0] helpSeg [0:3] = '{8'h89, 8'h86, 8'hC7, 8'h8C};
    logic [7:0] mixSeg  [0:7] = '{8'h88, 8'h83, 8'hBF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    ascii_7seg_scan #(
        .NUM_DIGITS (ND),
        .BUF_DEPTH  (BD),
        .REFRESH_DIV(RD),
        .SCROLL_DIV (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .scroll_en  (scroll_en),
        .msg_len    (msg_len),
        .seg        (seg),
        .an         (an),
        .scroll_wrap(scroll_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Digit shown on the pins after edge n (n counted from reset release, first edge = 1).
    function automatic int digit_at(input int n);
        return ((n - 1) / RD) % ND;
    endfunction

    function automatic logic [3:0] an_at(input int n);
        logic [3:0] onehot;
        onehot = 4'b1000 >> digit_at(n);
        return ~onehot;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_char(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back('{an: 4'hF, seg: 8'hFF, wrap: 1'b0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL reset_hold: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
        rst_n = 1'b1;
        cyc = 0;
        expQ.push_back('{an: 4'h7, seg: 8'hFF, wrap: 1'b0});
        tick();
        e = expQ.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
            errors++;
            $display("FAIL reset_release: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                     an, seg, scroll_wrap, e.an, e.seg, e.wrap);
        end
    endtask

    task automatic test_static();
        exp_t e;
        write_char(3'd0, 8'h48);  // 'H'
        write_char(3'd1, 8'h65);  // 'e'
        write_char(3'd2, 8'h4C);  // 'L'
        write_char(3'd3, 8'h50);  // 'P'
        for (int n = cyc + 1; n <= cyc + 16; n++)
            expQ.push_back('{an: an_at(n), seg: helpSeg[digit_at(n)], wrap: 1'b0});
        for (int i = 0; i < 16; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL static_help n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    task automatic test_dp();
        exp_t e;
        int   d;
        write_char(3'd0, 8'hB0);
        for (int n = cyc + 1; n <= cyc + 16; n++) begin
            d = digit_at(n);
            expQ.push_back('{an: an_at(n), seg: (d == 0) ? 8'h40 : helpSeg[d], wrap: 1'b0});
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL decimal_point n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    task automatic test_scroll_wrap();
        exp_t e;
        int   c0;
        int   o;
        int   wraps;
        for (int a = 0; a < 6; a++) write_char(3'(a), 8'(8'h30 + a));
        msg_len   = 4'd6;
        scroll_en = 1'b1;
        c0 = cyc;
        wraps = 0;
        for (int n = c0 + 1; n <= c0 + 400; n++) begin
            o = ((n - c0 - 1) / SD) % 6;
            expQ.push_back('{an: an_at(n), seg: numSeg[(o + digit_at(n)) % 6],
                             wrap: ((n - c0) % 192) == 0});
        end
        for (int i = 0; i < 400; i++) begin
            tick();
            if (scroll_wrap === 1'b1) wraps++;
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL scroll_wrap n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
        checks++;
        if (wraps !== 2) begin
            errors++;
            $display("FAIL scroll_wrap_count: got %0d pulses, want 2", wraps);
        end
    endtask

    task automatic test_short_msg();
        exp_t e;
        msg_len = 4'd3;
        for (int n = cyc + 1; n <= cyc + 48; n++)
            expQ.push_back('{an: an_at(n), seg: numSeg[digit_at(n)], wrap: 1'b0});
        for (int i = 0; i < 48; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL short_msg n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    task automatic test_mid_scroll_reset();
        exp_t e;
        int   c1;
        msg_len = 4'd6;
        c1 = cyc;
        for (int n = c1 + 1; n <= c1 + 170; n++)
            expQ.push_back('{an: an_at(n),
                             seg: numSeg[(((n - c1 - 1) / SD) % 6 + digit_at(n)) % 6],
                             wrap: 1'b0});
        for (int i = 0; i < 170; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL mid_scroll_run n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
        // Offset is 5 here; shrinking to 4 must snap it back to 0 without a pulse.
        msg_len = 4'd4;
        tick();
        for (int n = cyc + 1; n <= cyc + 19; n++)
            expQ.push_back('{an: an_at(n), seg: numSeg[digit_at(n)], wrap: 1'b0});
        for (int i = 0; i < 19; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL mid_scroll_shrink n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
        rst_n     = 1'b0;
        scroll_en = 1'b0;
        msg_len   = 4'd0;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back('{an: 4'hF, seg: 8'hFF, wrap: 1'b0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL mid_frame_reset: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
        rst_n = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 17; n++)
            expQ.push_back('{an: an_at(n), seg: 8'hFF, wrap: 1'b0});
        for (int i = 0; i < 17; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL buffer_cleared n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    task automatic test_write_latency();
        exp_t e;
        while ((cyc % 16) != 0) tick();
        expQ.push_back('{an: an_at(cyc + 1), seg: 8'hFF, wrap: 1'b0});
        expQ.push_back('{an: an_at(cyc + 2), seg: 8'h88, wrap: 1'b0});
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'h61;  // 'a'
        for (int i = 0; i < 2; i++) begin
            tick();
            wr_en = 1'b0;
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL write_latency n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] data [1:3] = '{8'h62, 8'h2D, 8'hFA};
        // Each write lands on a refresh terminal-count edge.
        for (int a = 1; a <= 3; a++) begin
            while ((cyc % 4) != 3) tick();
            write_char(3'(a), data[a]);
        end
        for (int n = cyc + 1; n <= cyc + 16; n++)
            expQ.push_back('{an: an_at(n), seg: mixSeg[digit_at(n)], wrap: 1'b0});
        for (int i = 0; i < 16; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL back_to_back n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    task automatic test_len_clamp();
        exp_t e;
        int   c;
        msg_len   = 4'd15;
        scroll_en = 1'b1;
        c = cyc;
        for (int n = c + 1; n <= c + 300; n++)
            expQ.push_back('{an: an_at(n),
                             seg: mixSeg[(((n - c - 1) / SD) % 8 + digit_at(n)) % 8],
                             wrap: ((n - c) % 256) == 0});
        for (int i = 0; i < 300; i++) begin
            tick();
            e = expQ.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || scroll_wrap !== e.wrap) begin
                errors++;
                $display("FAIL len_clamp n=%0d: got an=%h seg=%h wrap=%b, want an=%h seg=%h wrap=%b",
                         cyc, an, seg, scroll_wrap, e.an, e.seg, e.wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_dp();
        test_scroll_wrap();
        test_short_msg();
        test_mid_scroll_reset();
        test_write_latency();
        test_back_to_back();
        test_len_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
